// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit register ALU and its command sequencer:
// opcodes, flag bit positions and the sequencer state encoding.
package alu_pkg;

    // ALU opcodes as carried on cmd_op and replayed on alu_data during LD_OP
    typedef enum logic [1:0] {
        OP_NOR  = 2'd0,
        OP_NAND = 2'd1,
        OP_ADD  = 2'd2,
        OP_SUB  = 2'd3
    } alu_op_e;

    // Bit positions inside the 5-bit flag vector {V,C,Z,Neg,P}
    localparam int unsigned FLG_V = 4;
    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_P = 0;
    localparam int unsigned FLG_W = 5;

    // Sequencer states, in replay order
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_A  = 3'd1,
        ST_LD_B  = 3'd2,
        ST_LD_OP = 3'd3,
        ST_UPD   = 3'd4,
        ST_CAPT  = 3'd5,
        ST_RESP  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Front-end sequencer for the register ALU. Accepts one {op,a,b} command per
// handshake, replays it onto the ALU's shared data bus and load strobes as
// LOAD_A -> LOAD_B -> LOAD_OP -> UPDATE, captures the registered result and
// flags, and returns them on a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    output logic [N-1:0]     alu_data,
    output logic             alu_load_a,
    output logic             alu_load_b,
    output logic             alu_load_op,
    output logic             alu_update,
    input  logic [N-1:0]     alu_result,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    import alu_pkg::*;

    seq_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     alu_data_q, alu_data_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             load_op_q, load_op_d;
    logic             update_q, update_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [N-1:0]     rsp_result_q, rsp_result_d;
    logic [4:0]       rsp_flags_q, rsp_flags_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    // Next-state, command latch, response capture and counter update
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        done_count_d = done_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = ST_LD_A;
                end
            end
            ST_LD_A:  state_d = ST_LD_B;
            ST_LD_B:  state_d = ST_LD_OP;
            ST_LD_OP: state_d = ST_UPD;
            ST_UPD:   state_d = ST_CAPT;
            ST_CAPT: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they leave a flop in step with state_q
    always_comb begin
        alu_data_d  = '0;
        load_a_d    = 1'b0;
        load_b_d    = 1'b0;
        load_op_d   = 1'b0;
        update_d    = 1'b0;
        rsp_valid_d = 1'b0;

        unique case (state_d)
            ST_LD_A: begin
                load_a_d   = 1'b1;
                alu_data_d = a_d;
            end
            ST_LD_B: begin
                load_b_d   = 1'b1;
                alu_data_d = b_d;
            end
            ST_LD_OP: begin
                load_op_d  = 1'b1;
                alu_data_d = {{(N-2){1'b0}}, op_d};
            end
            ST_UPD:  update_d    = 1'b1;
            ST_RESP: rsp_valid_d = 1'b1;
            default: ;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any partial command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_data_q   <= '0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_op_q    <= 1'b0;
            update_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            alu_data_q   <= alu_data_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            load_op_q    <= load_op_d;
            update_q     <= update_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            done_count_q <= done_count_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_data    = alu_data_q;
    assign alu_load_a  = load_a_q;
    assign alu_load_b  = load_b_q;
    assign alu_load_op = load_op_q;
    assign alu_update  = update_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign busy        = busy_q;
    assign done_count  = done_count_q;

endmodule
